// File: rtl/async_fifo_wptr_full.sv
// rtl/async_fifo_wptr_full.sv - write-side pointer, read-pointer synchronizer and full/almost-full/overflow flags
module async_fifo_wptr_full #(
    parameter int ADDR_WIDTH = 7,
    parameter int AF_GAP     = 2
) (
    input  logic                  in_clk,
    input  logic                  in_rstn,
    input  logic                  in_wr_en,
    input  logic [ADDR_WIDTH:0]   in_rptr_gray,
    output logic [ADDR_WIDTH-1:0] out_waddr,
    output logic [ADDR_WIDTH:0]   out_wptr_gray,
    output logic                  out_wr_ack,
    output logic                  out_full,
    output logic                  out_almost_full,
    output logic                  out_overflow
);

    localparam int PW    = ADDR_WIDTH + 1;
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] AF_LEVEL = PW'(DEPTH - AF_GAP);

    logic [ADDR_WIDTH:0] wbin_q, wbin_d;
    logic [ADDR_WIDTH:0] wgray_q, wgray_d;
    logic [ADDR_WIDTH:0] rq1_q, rq2_q;
    logic [ADDR_WIDTH:0] rbin, occ, full_img;
    logic                full_q, full_d;
    logic                af_q, af_d;
    logic                ovf_q, ovf_d;
    logic                accept;

    assign accept = in_wr_en & ~full_q;

    always_comb begin
        rbin     = '0;
        // Each binary bit is the XOR of all Gray bits at or above it.
        for (int i = 0; i < PW; i++) begin
            rbin[i] = ^(rq2_q >> i);
        end
        wbin_d   = wbin_q + {{ADDR_WIDTH{1'b0}}, accept};
        wgray_d  = wbin_d ^ (wbin_d >> 1);
        // Full when the write pointer is exactly one lap ahead of the read pointer.
        full_img = {~rq2_q[ADDR_WIDTH:ADDR_WIDTH-1], rq2_q[ADDR_WIDTH-2:0]};
        full_d   = (wgray_d == full_img);
        occ      = wbin_d - rbin;
        af_d     = (occ >= AF_LEVEL);
        ovf_d    = ovf_q | (in_wr_en & full_q);
    end

    always_ff @(posedge in_clk or negedge in_rstn) begin
        if (!in_rstn) begin
            wbin_q  <= '0;
            wgray_q <= '0;
            rq1_q   <= '0;
            rq2_q   <= '0;
            full_q  <= 1'b0;
            af_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            wbin_q  <= wbin_d;
            wgray_q <= wgray_d;
            rq1_q   <= in_rptr_gray;
            rq2_q   <= rq1_q;
            full_q  <= full_d;
            af_q    <= af_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out_waddr       = wbin_q[ADDR_WIDTH-1:0];
    assign out_wptr_gray   = wgray_q;
    assign out_wr_ack      = accept;
    assign out_full        = full_q;
    assign out_almost_full = af_q;
    assign out_overflow    = ovf_q;

endmodule
